// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 4-bit ALU datapath: owns R0-R3, queues ALU
// commands in a small FIFO and runs each through READ -> EXEC -> WB.
`timescale 1ns/1ps
module alu_seq_ctrl #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd,
    output logic        cmd_ready,
    input  logic        ld_valid,
    input  logic [1:0]  ld_addr,
    input  logic [3:0]  ld_data,
    output logic        ld_ready,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_func,
    input  logic [3:0]  alu_res,
    output logic [15:0] regs,
    output logic        busy,
    output logic        done,
    output logic        zero
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] rf_q, rf_d;
    logic [3:0]      opa_q, opa_d;
    logic [3:0]      opb_q, opb_d;
    logic [1:0]      func_q, func_d;
    logic [1:0]      dst_q, dst_d;
    logic [3:0]      res_q, res_d;
    logic            done_q, done_d;
    logic            zero_q, zero_d;

    logic       push, pop, pending;
    logic [7:0] head;

    assign cmd_ready = (cnt_q < DEPTH_C);
    assign ld_ready  = (state_q != S_WB);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_READ);
    // A push in this cycle is enough to start READ next cycle.
    assign pending   = (cnt_q != '0) || push;
    assign head      = mem_q[rd_ptr_q];

    assign alu_a    = opa_q;
    assign alu_b    = opb_q;
    assign alu_func = func_q;
    assign regs     = {rf_q[0], rf_q[1], rf_q[2], rf_q[3]};
    assign busy     = (state_q != S_IDLE) || (cnt_q != '0);
    assign done     = done_q;
    assign zero     = zero_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pending) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = pending ? S_READ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rf_d   = rf_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        func_d = func_q;
        dst_d  = dst_q;
        res_d  = res_q;
        zero_d = zero_q;
        done_d = 1'b0;
        // Operands come from rf_q, so a same-cycle load is not seen by READ.
        if (state_q == S_READ) begin
            opa_d  = rf_q[head[3:2]];
            opb_d  = rf_q[head[1:0]];
            func_d = head[7:6];
            dst_d  = head[5:4];
        end
        if (state_q == S_EXEC) res_d = alu_res;
        if (state_q == S_WB) begin
            rf_d[dst_q] = res_q;
            zero_d      = (res_q == 4'h0);
            done_d      = 1'b1;
        end else if (ld_valid) begin
            rf_d[ld_addr] = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rf_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            func_q   <= '0;
            dst_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rf_q     <= rf_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            func_q   <= func_d;
            dst_q    <= dst_d;
            res_q    <= res_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: timestamp-based command model checked every cycle,
// plus directed scenarios with hand-computed register images.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd;
    logic        ld_valid, ld_ready;
    logic [1:0]  ld_addr;
    logic [3:0]  ld_data;
    logic [3:0]  alu_a, alu_b, alu_res;
    logic [1:0]  alu_func;
    logic [15:0] regs;
    logic        busy, done, zero;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_res(alu_res),
        .regs(regs), .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    // The external combinational ALU.
    always_comb begin
        case (alu_func)
            2'd0:    alu_res = alu_a + alu_b;
            2'd1:    alu_res = alu_a - alu_b;
            2'd2:    alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    // Model: each command carries accept cycle and READ cycle; everything
    // else (EXEC, WB, done) is a fixed offset from READ.
    typedef struct {
        logic [7:0] c;
        int         acc;
        int         rd;
        logic [3:0] res;
    } ent_t;

    ent_t       q[$];
    logic [3:0] mr [4];
    logic [3:0] ea, eb;
    logic [1:0] ef;
    logic       ez;
    int         cyc = 0;
    int         last_rd = -100;

    function automatic logic [3:0] alu_m(logic [1:0] f, logic [3:0] a, logic [3:0] b);
        int s;
        case (f)
            2'd0:    s = (int'(a) + int'(b)) % 16;
            2'd1:    s = (int'(a) - int'(b) + 16) % 16;
            2'd2:    s = int'(a & b);
            default: s = int'(a | b);
        endcase
        return 4'(s);
    endfunction

    function automatic int cnt_at(int c);
        int n = 0;
        foreach (q[i]) if (q[i].acc < c && c <= q[i].rd) n++;
        return n;
    endfunction

    function automatic bit wb_at(int c);
        foreach (q[i]) if (q[i].rd + 2 == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit active_at(int c);
        foreach (q[i]) if (q[i].rd <= c && c <= q[i].rd + 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit done_at(int c);
        foreach (q[i]) if (q[i].rd + 3 == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare();
        chk("regs", 32'(regs), 32'({mr[0], mr[1], mr[2], mr[3]}));
        chk("done", 32'(done), 32'(done_at(cyc)));
        chk("zero", 32'(zero), 32'(ez));
        chk("busy", 32'(busy), 32'(cnt_at(cyc) > 0 || active_at(cyc)));
        chk("cmd_ready", 32'(cmd_ready), 32'(cnt_at(cyc) < 2));
        chk("ld_ready", 32'(ld_ready), 32'(!wb_at(cyc)));
        chk("alu_ops", 32'({alu_func, alu_a, alu_b}), 32'({ef, ea, eb}));
    endtask

    task automatic model_update();
        int nr;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) mr[i] = 4'h0;
            ea = 4'h0; eb = 4'h0; ef = 2'd0; ez = 1'b0;
            last_rd = -100;
        end else begin
            foreach (q[i]) if (q[i].rd == cyc) begin
                ea = mr[q[i].c[3:2]];
                eb = mr[q[i].c[1:0]];
                ef = q[i].c[7:6];
                q[i].res = alu_m(ef, ea, eb);
            end
            foreach (q[i]) if (q[i].rd + 2 == cyc) begin
                mr[q[i].c[5:4]] = q[i].res;
                ez = (q[i].res == 4'h0);
            end
            if (ld_valid && !wb_at(cyc)) mr[ld_addr] = ld_data;
            if (cmd_valid && cnt_at(cyc) < 2) begin
                nr = (cyc + 1 > last_rd + 3) ? cyc + 1 : last_rd + 3;
                last_rd = nr;
                q.push_back('{c: cmd, acc: cyc, rd: nr, res: 4'h0});
            end
            while (q.size() > 0 && q[0].rd + 3 <= cyc) void'(q.pop_front());
        end
        cyc++;
    endtask

    // One cycle: check outputs mid-cycle, advance the model on the edge,
    // then leave the bench 1ns after the edge where inputs change.
    task automatic step();
        @(negedge clk);
        if (!rst) compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic issue(input logic [7:0] c);
        cmd_valid = 1'b1; cmd = c;
        step();
        cmd_valid = 1'b0;
    endtask

    // Called right after the accepting step, i.e. in cycle 1.
    task automatic wait_done(input string nm);
        int n = 1;
        while (done !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk(nm, 32'(n), 32'd4);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        cmd_valid = 1'b0; cmd = 8'h00;
        ld_valid = 1'b0; ld_addr = 2'd0; ld_data = 4'h0;
        for (int i = 0; i < 4; i++) mr[i] = 4'h0;
        ea = 4'h0; eb = 4'h0; ef = 2'd0; ez = 1'b0;
        step(); step();
        chk("rst_regs", 32'(regs), 32'h0);
        chk("rst_flags", 32'({busy, done, zero, cmd_ready, ld_ready}), 32'b00011);
        rst = 1'b0;

        // ADD R2 = R0 + R1 with 3 and 5
        load(2'd0, 4'h3); load(2'd1, 4'h5);
        issue(8'h21);
        wait_done("add_latency");
        chk("add_regs", 32'(regs), 32'h3580);
        chk("add_zero", 32'(zero), 32'h0);

        // SUB R3 = 0 - 1, then AND R2 = R3 & R0
        load(2'd0, 4'h0); load(2'd1, 4'h1);
        issue(8'h71);
        wait_done("sub_latency");
        chk("sub_regs", 32'(regs), 32'h018F);
        issue(8'hAC);
        wait_done("and_latency");
        chk("and_regs", 32'(regs), 32'h010F);
        chk("and_zero", 32'(zero), 32'h1);

        // Dependency chain R0 = R0 + R1, three back-to-back
        load(2'd0, 4'h1); load(2'd1, 4'h1);
        issue(8'h01); issue(8'h01); issue(8'h01);
        chk("chain_full", 32'(cmd_ready), 32'h0);
        step();
        chk("chain_done4", 32'({done, regs[15:12]}), 32'h12);
        step();
        chk("chain_gap5", 32'(done), 32'h0);
        step(); step();
        chk("chain_done7", 32'({done, regs[15:12]}), 32'h13);
        step(); step(); step();
        chk("chain_done10", 32'({done, regs[15:12]}), 32'h14);
        chk("chain_regs", 32'(regs), 32'h410F);

        // Continuous load to R0 starting in READ of ADD R2 = R0 + R1
        issue(8'h21);
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 4'h7;
        chk("ld_rdy_read", 32'(ld_ready), 32'h1);
        step();
        chk("ld_rdy_exec", 32'(ld_ready), 32'h1);
        step();
        chk("ld_rdy_wb", 32'(ld_ready), 32'h0);
        step();
        ld_valid = 1'b0;
        chk("ld_read_regs", 32'({done, regs}), 32'h1715F);

        // Wrap-around and OR
        load(2'd0, 4'hF); load(2'd1, 4'h1);
        issue(8'h21);
        wait_done("wrap_latency");
        chk("wrap_regs", 32'(regs), 32'hF10F);
        chk("wrap_zero", 32'(zero), 32'h1);
        load(2'd0, 4'hA); load(2'd1, 4'h5);
        issue(8'hF1);
        wait_done("or_latency");
        chk("or_regs", 32'(regs), 32'hA50F);
        chk("or_zero", 32'(zero), 32'h0);

        // Reset in EXEC with further work queued; nothing may be written back
        issue(8'h21); issue(8'h21);
        cmd_valid = 1'b1; cmd = 8'h21;
        rst = 1'b1;
        #1;
        cmd_valid = 1'b0;
        chk("midrst_regs", 32'(regs), 32'h0);
        chk("midrst_flags", 32'({busy, done, zero, cmd_ready, ld_ready}), 32'b00011);
        chk("midrst_alu", 32'({alu_func, alu_a, alu_b}), 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("post_rst_regs", 32'({busy, done, regs}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer for the 4-bit ALU datapath on the board top level. It owns a 4-entry × 4-bit register file (R0–R3), buffers incoming ALU commands in a small FIFO, and runs each one through a READ → EXEC → WB state machine. The external combinational ALU (00 add, 01 sub, 10 AND, 11 OR) is driven from latched operands. Commands and direct register loads come from debounced button/switch logic; the packed register view feeds the 7-segment display driver.

## Interface
- FIFO_DEPTH, 2 — command FIFO entries; power of two, ≥ 2

- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd  in  8  {func[7:6], dst[5:4], srcA[3:2], srcB[1:0]}
- cmd_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH)
- ld_valid  in  1  direct register load request
- ld_addr  in  2  load target register
- ld_data  in  4  load value
- ld_ready  out  1  load accepted this cycle; low only in WB
- alu_a, alu_b  out  4 each  ALU operands
- alu_func  out  2  ALU function select
- alu_res  in  4  ALU result, combinational from alu_a/alu_b/alu_func
- regs  out  16  {R0, R1, R2, R3}, R0 in [15:12]
- busy  out  1  state ≠ IDLE or FIFO non-empty
- done  out  1  one-cycle pulse per completed command
- zero  out  1  set when last written-back result == 0

## Operation
- Push on cmd_valid && cmd_ready. cmd_ready does not consider a same-cycle pop: when full it stays low even if a pop happens that cycle.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE → READ when the FIFO is non-empty.
  - READ: pop the head entry. Latch opA = R[srcA], opB = R[srcB], func, dst. Go to EXEC.
  - EXEC: alu_a = opA, alu_b = opB, alu_func = func, all stable for the whole cycle. Sample alu_res into res at the end of the cycle. Go to WB.
  - WB: R[dst] <= res, zero <= (res == 0), done <= 1 (registered). Go to READ if the FIFO is non-empty (counted after any push this cycle), else IDLE.
- Outside EXEC, alu_a, alu_b and alu_func hold their last latched values.
- Arithmetic is fully in the ALU. All values are 4-bit modulo 16: carry and borrow are discarded (e.g. 0xF + 0x1 = 0x0, 0x0 − 0x1 = 0xF).
- Direct load: when ld_valid && ld_ready, R[ld_addr] <= ld_data. This is accepted in IDLE, READ and EXEC.
  - Load during READ to a source register: READ latches the pre-load value.
  - The load becomes visible from the next cycle.
- Reading a register written by the previous command is always correct, because its WB commits before the next READ samples.
- Reset, including mid-command: FIFO emptied, state IDLE, R0–R3 = 0, opA/opB/func/res = 0. Outputs: regs = 0, alu_a = alu_b = 0, alu_func = 0, done = 0, zero = 0, busy = 0, cmd_ready = 1, ld_ready = 1. An in-flight command is lost.

## Timing
- Cycle 0: command accepted into an empty FIFO while IDLE.
- Cycle 1: READ. Cycle 2: EXEC. Cycle 3: WB.
- Cycle 4: the new value is visible on regs, done = 1, zero is valid.
- Back-to-back throughput: one command per 3 cycles (WB → READ directly).
- done is high for exactly one cycle per command and never for two consecutive cycles.
- busy rises the cycle after the first accept and falls the cycle after the last WB with the FIFO empty.

## Test plan
- Reset mid-EXEC, with two commands still queued → next cycle: regs = 0x0000, busy = 0, done = 0, cmd_ready = 1. No later writeback occurs.
- Load R0 = 3, R1 = 5; then cmd {00, dst 2, srcA 0, srcB 1} → done at cycle 4 after accept, regs = 0x3580, zero = 0.
- R0 = 0, R1 = 1; cmd SUB dst 3, srcA 0, srcB 1 → R3 = 0xF. Then AND R3 with R0 into R2 → R2 = 0, zero = 1.
- Dependency chain: ADD R0 = R0 + R1, issued three times back-to-back with R0 = 1, R1 = 1 → done pulses at cycles 4, 7, 10; R0 = 2, 3, 4. The FIFO fills, so cmd_ready is low while count = 2.
- ld_valid asserted continuously during a command → ld_ready = 0 only in the WB cycle. A load to a source register in the READ cycle does not change that command's operand.
- Wrap: R0 = 0xF, R1 = 0x1, ADD → 0x0 and zero = 1. OR 0xA with 0x5 → 0xF.
